bcd_converter: RTL and testbench

Sequential double-dabble converter that turns the signed 16-bit SPM product into a 20-bit, 5-digit BCD magnitude and a sign flag. It sits directly upstream of the digit-window selection FSM, which consumes the 20-bit BCD word. It also feeds the sign indicator on the display. The BCD output is registered and changes only when a conversion completes, so the display never shows intermediate shift values.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_add3.sv | 23 ++
 rtl/bcd_converter.sv | 113 +++++++++++
 tb/tb_bcd_converter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
// bcd_pkg : shared constants and FSM encoding for the BCD conversion path
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int BCD_WIDTH  = 16;
  localparam int BCD_DIGITS = 5;
  // The downstream window FSM slices the BCD word with this same digit width.
  localparam int DIGIT_W    = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ============================================================================
// bcd_add3 : double-dabble digit correction, adds 3 when the digit is >= 5
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_in,
  output logic [DIGIT_W-1:0] d_out
);

  always_comb begin
    d_out = d_in;
    if (d_in >= DIGIT_W'(5)) begin
      d_out = d_in + DIGIT_W'(3);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_converter.sv
// ============================================================================
// bcd_converter : sequential double-dabble, signed binary -> BCD magnitude
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bcd_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            bin_in,
  output logic [DIGIT_W*DIGITS-1:0]   bcd,
  output logic                        sign,
  output logic                        busy,
  output logic                        done
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_pend_q, sign_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d_in  (scratch_q[i*DIGIT_W +: DIGIT_W]),
      .d_out (scratch_adj[i*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    sign_pend_d = sign_pend_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // The most negative input maps to 2^(WIDTH-1), still fits unsigned.
          mag_d       = bin_in[WIDTH-1] ? (~bin_in + WIDTH'(1)) : bin_in;
          sign_pend_d = bin_in[WIDTH-1];
          scratch_d   = '0;
          cnt_d       = '0;
          state_d     = CONVERT;
        end
      end
      CONVERT: begin
        scratch_d = {scratch_adj[BCD_W-2:0], mag_q[WIDTH-1]};
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_d   = scratch_d;
          sign_d  = sign_pend_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CONVERT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      sign_pend_q <= 1'b0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      sign_pend_q <= sign_pend_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign sign = sign_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_converter.sv
// ============================================================================
// tb_bcd_converter : directed vector table plus multi-cycle corner sequences
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_bcd_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin_in;
  logic [19:0] bcd;
  logic        sign;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (bin_in),
    .bcd    (bcd),
    .sign   (sign),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp_bcd;
    logic        exp_sign;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulses start for one cycle; k counts cycles after the accepting edge.
  task automatic run_conv(input logic [15:0] b, output logic [19:0] r_bcd,
                          output logic r_sign, output int lat,
                          output bit busy_ok, output bit one_pulse);
    @(negedge clk);
    start  = 1'b1;
    bin_in = b;
    @(negedge clk);
    start   = 1'b0;
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    r_bcd  = bcd;
    r_sign = sign;
    @(negedge clk);
    one_pulse = !done;
  endtask

  vec_t        vecs[11];
  logic [19:0] g_bcd;
  logic        g_sign;
  int          g_lat;
  bit          g_busy_ok;
  bit          g_one;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;

    vecs[0]  = '{16'h3039, 20'h12345, 1'b0};
    vecs[1]  = '{16'hC000, 20'h16384, 1'b1};
    vecs[2]  = '{16'h0000, 20'h00000, 1'b0};
    vecs[3]  = '{16'h7FFF, 20'h32767, 1'b0};
    vecs[4]  = '{16'h8000, 20'h32768, 1'b1};
    vecs[5]  = '{16'hFFFF, 20'h00001, 1'b1};
    vecs[6]  = '{16'h0063, 20'h00099, 1'b0};
    vecs[7]  = '{16'h0009, 20'h00009, 1'b0};
    vecs[8]  = '{16'h270F, 20'h09999, 1'b0};
    vecs[9]  = '{16'hD8F1, 20'h09999, 1'b1};
    vecs[10] = '{16'h0001, 20'h00001, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_bcd",  32'(bcd),  32'h0);
    check("reset_sign", 32'(sign), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    for (int i = 0; i < 11; i++) begin
      run_conv(vecs[i].bin, g_bcd, g_sign, g_lat, g_busy_ok, g_one);
      check($sformatf("v%0d_bcd", i),     32'(g_bcd),     32'(vecs[i].exp_bcd));
      check($sformatf("v%0d_sign", i),    32'(g_sign),    32'(vecs[i].exp_sign));
      check($sformatf("v%0d_latency", i), 32'(g_lat),     32'd17);
      check($sformatf("v%0d_busy", i),    32'(g_busy_ok), 32'd1);
      check($sformatf("v%0d_pulse", i),   32'(g_one),     32'd1);
    end

    // bcd must hold the previous result until done; a start during busy is dropped
    begin
      int  dones;
      int  first_done;
      bit  hold_ok;
      logic [19:0] got;
      run_conv(16'h3039, g_bcd, g_sign, g_lat, g_busy_ok, g_one);
      check("hold_pre_bcd", 32'(g_bcd), 32'h12345);
      @(negedge clk);
      start  = 1'b1;
      bin_in = 16'h0063;
      @(negedge clk);
      start      = 1'b0;
      dones      = 0;
      first_done = -1;
      hold_ok    = 1'b1;
      got        = '0;
      for (int k = 1; k <= 40; k++) begin
        if (k > 1) @(negedge clk);
        if (k == 5) begin
          start  = 1'b1;
          bin_in = 16'h0777;
        end else begin
          start = 1'b0;
        end
        if (done) begin
          dones++;
          if (first_done < 0) begin
            first_done = k;
            got        = bcd;
          end
        end else if (first_done < 0 && bcd !== 20'h12345) begin
          hold_ok = 1'b0;
        end
      end
      check("hold_bcd_stable", 32'(hold_ok),    32'd1);
      check("hold_done_at",    32'(first_done), 32'd17);
      check("hold_bcd_final",  32'(got),        32'h00099);
      check("hold_done_count", 32'(dones),      32'd1);
    end

    // start held high: second request accepted in the done cycle
    begin
      int d1;
      int d2;
      logic [19:0] b1;
      logic [19:0] b2;
      d1 = -1;
      d2 = -1;
      b1 = '0;
      b2 = '0;
      @(negedge clk);
      start  = 1'b1;
      bin_in = 16'h0001;
      @(negedge clk);
      for (int k = 1; k <= 60; k++) begin
        if (k > 1) @(negedge clk);
        if (k == 18) start = 1'b0;
        if (done) begin
          if (d1 < 0) begin
            d1     = k;
            b1     = bcd;
            bin_in = 16'h0002;
          end else if (d2 < 0) begin
            d2 = k;
            b2 = bcd;
          end
        end
      end
      check("b2b_first_at",   32'(d1), 32'd17);
      check("b2b_first_bcd",  32'(b1), 32'h00001);
      check("b2b_second_gap", 32'(d2 - d1), 32'd17);
      check("b2b_second_bcd", 32'(b2), 32'h00002);
    end

    // reset in the middle of a conversion discards it
    begin
      int seen;
      @(negedge clk);
      start  = 1'b1;
      bin_in = 16'h1234;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_bcd",  32'(bcd),  32'h0);
      check("midrst_sign", 32'(sign), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        if (done) seen++;
        @(negedge clk);
      end
      check("midrst_no_done", 32'(seen), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
